// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module divider_step #(
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic [DATA_WIDTH_2:0]   rem,
  input  logic                    bit_in,
  input  logic [DATA_WIDTH_2-1:0] divisor,
  output logic [DATA_WIDTH_2:0]   rem_next,
  output logic                    q_bit
);

  logic [DATA_WIDTH_2+1:0] shifted;
  logic [DATA_WIDTH_2+1:0] trial;

  assign shifted  = {rem, bit_in};
  assign trial    = shifted - {2'b00, divisor};
  // Top bit of trial is the borrow: clear means the subtract fit.
  assign q_bit    = ~trial[DATA_WIDTH_2+1];
  assign rem_next = q_bit ? trial[DATA_WIDTH_2:0]
                          : shifted[DATA_WIDTH_2:0];

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// start/busy/valid handshake, results held until the next operation.
module divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [DATA_WIDTH_1-1:0] dividend_i,
  input  logic [DATA_WIDTH_2-1:0] divisor_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH_1-1:0] quotient_o,
  output logic [DATA_WIDTH_2-1:0] remainder_o,
  output logic                    div_by_zero_o
);

  localparam int CW = cnt_width(DATA_WIDTH_1);

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH_1-1:0] dvd;
  logic [DATA_WIDTH_2-1:0] dvs;
  logic [DATA_WIDTH_2:0]   rem;
  logic [DATA_WIDTH_2:0]   rem_next;
  logic [CW-1:0]           cnt;
  logic                    q_bit;
  logic                    accept;
  logic                    zero_div;
  logic                    last;

  assign accept   = start_i && (state != CALC);
  assign zero_div = (divisor_i == '0);
  assign last     = (cnt == CW'(1));

  divider_step #(
    .DATA_WIDTH_2(DATA_WIDTH_2)
  ) u_step (
    .rem     (rem),
    .bit_in  (dvd[DATA_WIDTH_1-1]),
    .divisor (dvs),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = zero_div ? DONE : CALC;
        else        state_next = IDLE;
      end
      CALC:    state_next = last ? DONE : CALC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state)
      CALC:    busy_o  = 1'b1;
      DONE:    valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      cnt           <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient_o    <= '1;
        remainder_o   <= '0;
        div_by_zero_o <= 1'b1;
      end else begin
        dvd <= dividend_i;
        dvs <= divisor_i;
        rem <= '0;
        cnt <= CW'(DATA_WIDTH_1);
      end
    end else if (state == CALC) begin
      dvd <= {dvd[DATA_WIDTH_1-2:0], q_bit};
      rem <= rem_next;
      cnt <= cnt - CW'(1);
      if (last) begin
        quotient_o    <= {dvd[DATA_WIDTH_1-2:0], q_bit};
        remainder_o   <= rem_next[DATA_WIDTH_2-1:0];
        div_by_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: scoreboard of expected results,
// one task per scenario, latency and busy checks done inline.
module tb_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [7:0] divisor_i;
  logic       busy_o;
  logic       valid_o;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
  logic       div_by_zero_o;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   passed = 0;
  int   cyc;
  int   bsy;

  divider #(
    .DATA_WIDTH_1(8),
    .DATA_WIDTH_2(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  // Drive at a negedge; the next posedge samples it.
  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    if (b == 8'd0) sb.push_back('{8'hff, 8'd0, 1'b1});
    else           sb.push_back('{a / b, a % b, 1'b0});
  endtask

  // Step negedges until valid_o; counts cycles and busy-high samples.
  task automatic wait_valid(input bit hold, output int n, output int b);
    n = 0;
    b = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) start_i = 1'b0;
      if (busy_o) b++;
    end while (!valid_o && n < 40);
    if (!valid_o) begin
      total++;
      $display("FAIL timeout: no valid_o within %0d cycles", n);
    end
  endtask

  task automatic pop_exp(input string tag);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: valid_o with empty scoreboard", tag);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o} !== 19'd0)
      $display("FAIL reset_outputs: got b%0b v%0b q%0d r%0d z%0b want all 0",
               busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o);
    else passed++;
  endtask

  task automatic test_basic;
    drive(8'd34, 8'd22);
    wait_valid(1'b0, cyc, bsy);
    pop_exp("basic");
    total++;
    if (quotient_o !== e.q) $display("FAIL basic_q: got %0d want %0d", quotient_o, e.q);
    else passed++;
    total++;
    if (remainder_o !== e.r) $display("FAIL basic_r: got %0d want %0d", remainder_o, e.r);
    else passed++;
    total++;
    if (div_by_zero_o !== 1'b0) $display("FAIL basic_dz: got %0b want 0", div_by_zero_o);
    else passed++;
    total++;
    if (cyc !== 9) $display("FAIL basic_latency: got %0d want 9", cyc);
    else passed++;
    total++;
    if (bsy !== 8) $display("FAIL basic_busy: got %0d want 8", bsy);
    else passed++;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || quotient_o !== e.q)
      $display("FAIL basic_hold: got v%0b q%0d want v0 q%0d", valid_o, quotient_o, e.q);
    else passed++;
  endtask

  task automatic test_back_to_back;
    drive(8'd99, 8'd9);
    @(negedge clk);
    dividend_i = 8'd9;
    divisor_i  = 8'd99;
    sb.push_back('{8'd0, 8'd9, 1'b0});
    wait_valid(1'b1, cyc, bsy);
    pop_exp("b2b_first");
    total++;
    if ({quotient_o, remainder_o} !== {e.q, e.r})
      $display("FAIL b2b_first: got q%0d r%0d want q%0d r%0d",
               quotient_o, remainder_o, e.q, e.r);
    else passed++;
    wait_valid(1'b1, cyc, bsy);
    start_i = 1'b0;
    pop_exp("b2b_second");
    total++;
    if ({quotient_o, remainder_o} !== {e.q, e.r})
      $display("FAIL b2b_second: got q%0d r%0d want q%0d r%0d",
               quotient_o, remainder_o, e.q, e.r);
    else passed++;
    total++;
    if (cyc !== 9) $display("FAIL b2b_gap: got %0d want 9", cyc);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_extremes;
    logic [7:0] a [2] = '{8'd255, 8'd255};
    logic [7:0] b [2] = '{8'd1, 8'd255};
    for (int i = 0; i < 2; i++) begin
      drive(a[i], b[i]);
      wait_valid(1'b0, cyc, bsy);
      pop_exp("extreme");
      total++;
      if ({quotient_o, remainder_o} !== {e.q, e.r})
        $display("FAIL extreme_%0d: got q%0d r%0d want q%0d r%0d",
                 i, quotient_o, remainder_o, e.q, e.r);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    drive(8'd200, 8'd0);
    wait_valid(1'b0, cyc, bsy);
    pop_exp("div0");
    total++;
    if ({quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz})
      $display("FAIL div0_result: got q%0d r%0d z%0b want q%0d r%0d z%0b",
               quotient_o, remainder_o, div_by_zero_o, e.q, e.r, e.dz);
    else passed++;
    total++;
    if (cyc !== 1) $display("FAIL div0_latency: got %0d want 1", cyc);
    else passed++;
    total++;
    if (bsy !== 0) $display("FAIL div0_busy: got %0d want 0", bsy);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int n;
    drive(8'd34, 8'd22);
    repeat (3) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    start_i    = 1'b1;
    dividend_i = 8'd99;
    divisor_i  = 8'd9;
    wait_valid(1'b0, cyc, bsy);
    pop_exp("ignored");
    total++;
    if ({quotient_o, remainder_o, div_by_zero_o} !== {e.q, e.r, e.dz})
      $display("FAIL ignored_result: got q%0d r%0d z%0b want q%0d r%0d z%0b",
               quotient_o, remainder_o, div_by_zero_o, e.q, e.r, e.dz);
    else passed++;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_o) n++;
    end
    total++;
    if (n !== 0) $display("FAIL ignored_extra_valid: got %0d want 0", n);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    start_i    = 1'b1;
    dividend_i = 8'd99;
    divisor_i  = 8'd9;
    repeat (3) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o} !== 19'd0)
      $display("FAIL midrst_outputs: got b%0b v%0b q%0d r%0d z%0b want all 0",
               busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o);
    else passed++;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_o) n++;
    end
    total++;
    if (n !== 0) $display("FAIL midrst_valid: got %0d want 0", n);
    else passed++;
    drive(8'd50, 8'd7);
    wait_valid(1'b0, cyc, bsy);
    pop_exp("midrst_next");
    total++;
    if ({quotient_o, remainder_o} !== {e.q, e.r})
      $display("FAIL midrst_next: got q%0d r%0d want q%0d r%0d",
               quotient_o, remainder_o, e.q, e.r);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      drive(a, b);
      wait_valid(1'b0, cyc, bsy);
      pop_exp("random");
      total++;
      if ({quotient_o, remainder_o} !== {e.q, e.r})
        $display("FAIL random_%0d %0d/%0d: got q%0d r%0d want q%0d r%0d",
                 i, a, b, quotient_o, remainder_o, e.q, e.r);
      else passed++;
    end
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_extremes;
    test_div_zero;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
